// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter for one shared preset-to-ones, CE-gated register bank.
// Optional ARB_LOCK_EN: winner keeps priority for up to LOCK_MAX consecutive grants.
module dff_share_arbiter #(
  parameter int                 NREQ     = 4,
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   INIT     = {WIDTH{1'b1}},
  parameter int                 LOCK_MAX = 4
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ*WIDTH-1:0]  DIN,
  output logic [NREQ-1:0]        GNT,
  output logic                   CE,
  output logic [WIDTH-1:0]       Q,
  output logic [15:0]            GNT_CNT
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] scan_w;
  logic [PW-1:0] win;
  logic [PW-1:0] next_ptr;
  logic          any_req;
  logic          found;
  int            scan_idx;

  assign any_req = |REQ;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    scan_w   = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && REQ[scan_idx]) begin
        found  = 1'b1;
        scan_w = PW'(scan_idx);
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic [7:0]    lock_cnt;
  logic [PW-1:0] last_w;
  logic          locked;

  assign locked = (lock_cnt != 8'd0) && (int'(lock_cnt) < LOCK_MAX) && REQ[last_w];
  assign win    = locked ? last_w : scan_w;

  // A repeated winner only extends the run while it is still under LOCK_MAX.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      lock_cnt <= 8'd0;
      last_w   <= '0;
    end else if (PRESET || !any_req) begin
      lock_cnt <= 8'd0;
    end else begin
      last_w <= win;
      if (locked) lock_cnt <= lock_cnt + 8'd1;
      else        lock_cnt <= 8'd1;
    end
  end
`else
  assign win = scan_w;
`endif

  assign next_ptr = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      Q       <= INIT;
      GNT     <= '0;
      CE      <= 1'b0;
      GNT_CNT <= 16'd0;
      ptr     <= '0;
    end else if (PRESET) begin
      Q   <= {WIDTH{1'b1}};
      GNT <= '0;
      CE  <= 1'b1;
    end else if (any_req) begin
      Q       <= DIN[int'(win)*WIDTH +: WIDTH];
      GNT     <= NREQ'(1) << win;
      CE      <= 1'b1;
      ptr     <= next_ptr;
      GNT_CNT <= (GNT_CNT == 16'hFFFF) ? GNT_CNT : GNT_CNT + 16'd1;
    end else begin
      GNT <= '0;
      CE  <= 1'b0;
    end
  end

endmodule
